addsub_chunked: RTL and testbench

Parametrised multicycle two's-complement adder/subtractor for the multicycle RISC datapath, replacing the fixed 8-bit combinational adder. Operands are latched on a start handshake and summed CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks. This trades latency for a short carry path so the ALU can grow to 32 bits without limiting the clock. Sum, carry-out and flags are held until the next accepted start.

---
 rtl/addsub_chunked_pkg.sv | 21 ++
 rtl/addsub_chunked_chunk.sv | 26 ++
 rtl/addsub_chunked.sv | 123 ++++++++++++
 tb/tb_addsub_chunked.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_chunked_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Chunk-index width; never zero so N = 1 still has a legal index register
   function automatic int idx_width(input int width, input int chunk);
      int n;
      n = num_chunks(width, chunk);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/addsub_chunked_chunk.sv
// Combinational CHUNK-bit ripple adder used once per clock by addsub_chunked.
module addsub_chunk
   import addsub_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic c;

   always_comb begin
      s = '0;
      c = ci;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/addsub_chunked.sv
// Multicycle two's-complement add/sub, CHUNK bits per clock, LSB chunk first.
// Define ADDSUB_CHUNKED_FLAGS_EN to compute ovf/zero; otherwise they are tied to 0.
module addsub_chunked
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = num_chunks(WIDTH, CHUNK);
   localparam int IW = idx_width(WIDTH, CHUNK);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, sum_nx;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [31:0]      base;
   logic [CHUNK-1:0] ca, cb, cs;
   logic             cc;
   logic             last;

   assign last = (idx == LAST);
   assign base = 32'(idx) * CHUNK;

   always_comb begin
      ca = a_r[base +: CHUNK];
      cb = b_r[base +: CHUNK];
   end

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (ca),
      .b  (cb),
      .ci (carry),
      .s  (cs),
      .co (cc)
   );

   // Sum is updated in place; sum_nx is the word as it stands after this chunk
   always_comb begin
      sum_nx = sum;
      sum_nx[base +: CHUNK] = cs;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         sum   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b ^ {WIDTH{sub}};
                  carry <= sub | cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               sum   <= sum_nx;
               carry <= cc;
               idx   <= idx + 1'b1;
               if (last) cout <= cc;
            end
            default: ;
         endcase
      end
   end

`ifdef ADDSUB_CHUNKED_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else if (state == RUN && last) begin
         ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_nx[WIDTH-1] != a_r[WIDTH-1]);
         zero <= ~|sum_nx;
      end
   end
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_chunked.sv
// Self-checking bench for addsub_chunked: three configurations (8/4, 32/8, 8/8) side by side.
module tb_addsub_chunked;

`ifdef ADDSUB_CHUNKED_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif
   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          rst, start, sub, cin;
   logic [31:0]   a, b;
   logic [7:0]    s0, s2;
   logic [31:0]   s1;
   logic [NI-1:0] busy, done, cout, ovf, zero;

   logic [34:0]   cap [NI];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   addsub_chunked #(.WIDTH(8), .CHUNK(4)) dut84 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a[7:0]), .b(b[7:0]), .busy(busy[0]), .done(done[0]),
      .sum(s0), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]));

   addsub_chunked #(.WIDTH(32), .CHUNK(8)) dut328 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a), .b(b), .busy(busy[1]), .done(done[1]),
      .sum(s1), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]));

   addsub_chunked #(.WIDTH(8), .CHUNK(8)) dut88 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a[7:0]), .b(b[7:0]), .busy(busy[2]), .done(done[2]),
      .sum(s2), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]));

   function automatic int wof(input int i);
      case (i)
         1:       return 32;
         default: return 8;
      endcase
   endfunction

   function automatic int nof(input int i);
      case (i)
         0:       return 2;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] sumof(input int i);
      case (i)
         0:       return {24'd0, s0};
         1:       return s1;
         default: return {24'd0, s2};
      endcase
   endfunction

   function automatic logic [34:0] outs(input int i);
      return {cout[i], ovf[i], zero[i], sumof(i)};
   endfunction

   // Reference: plain unsigned/signed integer arithmetic at the instance width
   function automatic logic [34:0] model(input int i, input logic [31:0] av, bv,
                                         input logic sv, cv);
      int          w;
      longint      m, half, ua, ub, sa, sb, t, r;
      logic [31:0] s;
      logic        co, ov, z;
      w    = wof(i);
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(av) & m;
      ub   = longint'(bv) & m;
      sa   = (ua >= half) ? ua - (m + 1) : ua;
      sb   = (ub >= half) ? ub - (m + 1) : ub;
      if (sv) begin
         t  = ua - ub;
         co = (ua >= ub);
         r  = sa - sb;
      end else begin
         t  = ua + ub + longint'(cv);
         co = (t > m);
         r  = sa + sb + longint'(cv);
      end
      s  = 32'(t & m);
      ov = (r >= half) || (r < -half);
      z  = (s == 32'd0);
      if (!FLAGS) begin
         ov = 1'b0;
         z  = 1'b0;
      end
      return {co, ov, z, s};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One start pulse; operands scrambled after the start edge; watches 8 cycles
   task automatic run_op(input logic [31:0] av, bv, input logic sv, cv);
      int dc [NI];
      int dn [NI];
      int bb [NI];
      @(negedge clk);
      a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
      for (int i = 0; i < NI; i++) begin
         dc[i] = 0; dn[i] = 0; bb[i] = 0; cap[i] = 'x;
      end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
         a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
         for (int i = 0; i < NI; i++) begin
            if (busy[i] !== (c <= nof(i))) bb[i]++;
            if (done[i] === 1'b1) begin
               dn[i]++;
               dc[i]  = c;
               cap[i] = outs(i);
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("latency%0d", i), 64'(dc[i]), 64'(nof(i) + 1));
         chk($sformatf("done_count%0d", i), 64'(dn[i]), 64'd1);
         chk($sformatf("busy%0d", i), 64'(bb[i]), 64'd0);
         chk($sformatf("hold%0d", i), 64'(outs(i)), 64'(cap[i]));
      end
   endtask

   typedef struct {
      int          inst;
      logic [31:0] a, b;
      logic        sub, cin;
      logic [31:0] s;
      logic        co, ov, z;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [31:0] ra, rb;
      logic        rs, rc;
      int          first [NI];
      int          prev  [NI];
      int          cnt   [NI];
      int          gap   [NI];
      int          dseen;

      tbl[0] = '{0, 32'hFF,       32'h02,       1'b1, 1'b0, 32'hFD,       1'b1, 1'b0, 1'b0};
      tbl[1] = '{0, 32'h04,       32'h04,       1'b1, 1'b0, 32'h00,       1'b1, 1'b0, 1'b1};
      tbl[2] = '{0, 32'h01,       32'hFC,       1'b1, 1'b0, 32'h05,       1'b0, 1'b0, 1'b0};
      tbl[3] = '{1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{1, 32'h00FFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h01000000, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{2, 32'h80,       32'h80,       1'b0, 1'b0, 32'h00,       1'b1, 1'b1, 1'b1};

      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("reset_ctl", 64'({busy, done, cout, ovf, zero}), 64'd0);
      chk("reset_sum", 64'({s0, s1, s2}), 64'd0);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         run_op(tbl[v].a, tbl[v].b, tbl[v].sub, tbl[v].cin);
         chk($sformatf("vec%0d", v), 64'(cap[tbl[v].inst]),
             64'({tbl[v].co, tbl[v].ov & FLAGS, tbl[v].z & FLAGS, tbl[v].s}));
      end

      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
         if (n % 8 == 0) rb = ra;
         run_op(ra, rb, rs, rc);
         for (int i = 0; i < NI; i++)
            chk($sformatf("rand%0d_i%0d", n, i), 64'(cap[i]), 64'(model(i, ra, rb, rs, rc)));
      end

      // start held high: accepted only in IDLE, so done repeats every N+2 cycles
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h0F0F_0F0F; sub = 1'b0; cin = 1'b0; start = 1'b1;
      for (int i = 0; i < NI; i++) begin
         first[i] = 0; prev[i] = 0; cnt[i] = 0; gap[i] = 0;
      end
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (done[i] === 1'b1) begin
               if (cnt[i] == 0) first[i] = c;
               else if (c - prev[i] != nof(i) + 2) gap[i]++;
               prev[i] = c;
               cnt[i]++;
            end
         end
      end
      start = 1'b0;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("hs_first%0d", i), 64'(first[i]), 64'(nof(i) + 1));
         chk($sformatf("hs_gap%0d", i), 64'(gap[i]), 64'd0);
         chk($sformatf("hs_count%0d", i), 64'(cnt[i]), 64'((24 - (nof(i) + 1)) / (nof(i) + 2) + 1));
      end
      repeat (8) @(negedge clk);

      // leave non-zero results, then abort an operation in its 2nd RUN cycle
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      @(negedge clk);
      a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
      dseen = 0;
      @(negedge clk);
      start = 1'b0;
      if (done[0] === 1'b1 || done[1] === 1'b1) dseen++;
      @(negedge clk);
      if (done[0] === 1'b1 || done[1] === 1'b1) dseen++;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ctl", 64'({busy, done, cout, ovf, zero}), 64'd0);
      chk("abort_sum", 64'({s0, s1, s2}), 64'd0);
      chk("abort_nodone", 64'(dseen), 64'd0);
      rst = 1'b0;
      run_op(32'h8000_0001, 32'h0000_0003, 1'b1, 1'b0);
      for (int i = 0; i < NI; i++)
         chk($sformatf("post_rst%0d", i), 64'(cap[i]),
             64'(model(i, 32'h8000_0001, 32'h0000_0003, 1'b1, 1'b0)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
